tim6_psc_counter: RTL

- Consumer side of the TIM6 prescaler path. It takes the buffered prescaler value (PSC preload) and transfers it into an internal shadow register on an update event.
- It divides the timer kernel clock by (shadow+1) and emits a one-cycle count-enable pulse to the TIM6 main counter.
- It also services the software update-generation request (UG) by reloading the shadow, restarting the prescaler and forwarding a one-cycle update event.

---
 rtl/tim6_psc_counter.sv | 89 ++++++++
 1 files changed

// File: rtl/tim6_psc_counter.sv
// TIM6 prescaler: loads the PSC preload into a shadow on update events and emits a
// count-enable pulse every shadow+1 enabled clocks. `TIM6_PSC_CNT_OUT_EN adds o_pcnt readback.
//
//  state  | meaning
//  IDLE   | cen low, prescaler frozen, no count pulses
//  RUN    | cen high, prescaler counting toward shadow
//  RELOAD | one cycle after ug: shadow reloaded, prescaler restarted
module tim6_psc_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] i_bpsc,
    input  logic             uev,
    input  logic             ug,
    output logic             o_ck_cnt,
    output logic [WIDTH-1:0] o_psc_shadow,
    output logic             o_ug_uev
`ifdef TIM6_PSC_CNT_OUT_EN
    ,
    output logic [WIDTH-1:0] o_pcnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic             ck_cnt_q, ck_cnt_d;
    logic             ug_uev_q, ug_uev_d;
    logic             terminal;

    assign terminal = (pcnt_q == shadow_q);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        pcnt_d   = pcnt_q;
        ck_cnt_d = 1'b0;
        ug_uev_d = 1'b0;
        if (ug) begin
            // ug wins over uev and drops any terminal pulse due this cycle
            state_d  = RELOAD;
            shadow_d = i_bpsc;
            pcnt_d   = '0;
            ug_uev_d = 1'b1;
        end else begin
            state_d = cen ? RUN : IDLE;
            if (cen) begin
                ck_cnt_d = terminal;
                pcnt_d   = terminal ? '0 : pcnt_q + 1'b1;
            end
            if (uev) begin
                shadow_d = i_bpsc;
                pcnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            pcnt_q   <= '0;
            ck_cnt_q <= 1'b0;
            ug_uev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            pcnt_q   <= pcnt_d;
            ck_cnt_q <= ck_cnt_d;
            ug_uev_q <= ug_uev_d;
        end
    end

    assign o_ck_cnt     = ck_cnt_q;
    assign o_psc_shadow = shadow_q;
    assign o_ug_uev     = ug_uev_q;
`ifdef TIM6_PSC_CNT_OUT_EN
    assign o_pcnt       = pcnt_q;
`endif

endmodule
